// File: rtl/ysyx_24080006_pkg.sv
// rtl/ysyx_24080006_pkg.sv - AXI channel types and arbiter enums for the NPC
package ysyx_24080006_pkg;

    localparam int ARB_IFU = 0;
    localparam int ARB_LSU = 1;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_arb_state_e;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_arb_state_e;

    typedef struct packed {
        logic [31:0] araddr;
        logic [3:0]  arid;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        arvalid;
        logic        rready;
    } axi_r_m2s_t;

    typedef struct packed {
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic [3:0]  rid;
        logic        rlast;
    } axi_r_s2m_t;

    typedef struct packed {
        logic [31:0] awaddr;
        logic [3:0]  awid;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        awvalid;
        logic        wvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        bready;
    } axi_w_m2s_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic        bvalid;
        logic [1:0]  bresp;
        logic [3:0]  bid;
    } axi_w_s2m_t;

    // Registered address-phase fields, shared shape for AR and AW
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axi_addr_t;

    function automatic axi_addr_t ar_of(input axi_r_m2s_t m);
        ar_of.addr  = m.araddr;
        ar_of.id    = m.arid;
        ar_of.len   = m.arlen;
        ar_of.size  = m.arsize;
        ar_of.burst = m.arburst;
    endfunction

    function automatic axi_addr_t aw_of(input axi_w_m2s_t m);
        aw_of.addr  = m.awaddr;
        aw_of.id    = m.awid;
        aw_of.len   = m.awlen;
        aw_of.size  = m.awsize;
        aw_of.burst = m.awburst;
    endfunction

endpackage

// File: rtl/npc_rr_arb2.sv
// rtl/npc_rr_arb2.sv - two-way round-robin picker, one-hot grant
module npc_rr_arb2
    import ysyx_24080006_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic r_last_lsu;

    // On contention, the requester not granted last wins
    always_comb begin
        gnt = 2'b00;
        if (req[ARB_IFU] && (!req[ARB_LSU] || r_last_lsu)) begin
            gnt[ARB_IFU] = 1'b1;
        end else if (req[ARB_LSU]) begin
            gnt[ARB_LSU] = 1'b1;
        end
    end

    // Remember the last winner; reset pretends the LSU went last so the IFU wins first
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_lsu <= 1'b1;
        end else if (update && (gnt != 2'b00)) begin
            r_last_lsu <= gnt[ARB_LSU];
        end
    end

endmodule

// File: rtl/npc_axi_arbiter.sv
// rtl/npc_axi_arbiter.sv - IFU/LSU arbiter in front of the NPC AXI crossbar
module npc_axi_arbiter
    import ysyx_24080006_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  axi_r_m2s_t ifu_r_m2s,
    output axi_r_s2m_t ifu_r_s2m,
    input  axi_r_m2s_t lsu_r_m2s,
    output axi_r_s2m_t lsu_r_s2m,
    input  axi_w_m2s_t lsu_w_m2s,
    output axi_w_s2m_t lsu_w_s2m,
    output axi_r_m2s_t imd_r_m2s,
    input  axi_r_s2m_t imd_r_s2m,
    output axi_w_m2s_t imd_w_m2s,
    input  axi_w_s2m_t imd_w_s2m,
    output logic [1:0] rd_grant,
    output logic       rd_err
);

    rd_arb_state_e r_rd_state, w_rd_next;
    wr_arb_state_e r_wr_state, w_wr_next;
    axi_addr_t     r_ar_q, r_aw_q, w_ar_sel;
    logic [7:0]    r_beat_cnt;
    logic [1:0]    r_rd_owner;
    logic          r_rd_err;
    logic [1:0]    w_ar_req, w_ar_gnt;
    logic          w_ar_take, w_owner_rready, w_r_beat;

    assign w_ar_req       = {lsu_r_m2s.arvalid, ifu_r_m2s.arvalid};
    assign w_ar_take      = (r_rd_state == R_IDLE) && (w_ar_req != 2'b00);
    assign w_ar_sel       = w_ar_gnt[ARB_LSU] ? ar_of(lsu_r_m2s) : ar_of(ifu_r_m2s);
    assign w_owner_rready = r_rd_owner[ARB_LSU] ? lsu_r_m2s.rready : ifu_r_m2s.rready;
    assign w_r_beat       = (r_rd_state == R_DATA) && imd_r_s2m.rvalid && w_owner_rready;
    assign rd_grant       = r_rd_owner;
    assign rd_err         = r_rd_err;

    npc_rr_arb2 u_rr (
        .clock  (clock),
        .reset  (reset),
        .req    (w_ar_req),
        .update (w_ar_take),
        .gnt    (w_ar_gnt)
    );

    // Read FSM state register
    always_ff @(posedge clock) begin
        if (reset) r_rd_state <= R_IDLE;
        else       r_rd_state <= w_rd_next;
    end

    // Read FSM next state: grant, issue AR, stream beats until rlast
    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (w_ar_take) w_rd_next = R_AR;
            R_AR:    if (imd_r_s2m.arready) w_rd_next = R_DATA;
            R_DATA:  if (w_r_beat && imd_r_s2m.rlast) w_rd_next = R_IDLE;
            default: w_rd_next = R_IDLE;
        endcase
    end

    // Read datapath: latch winner's AR, count beats, flag length mismatches
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ar_q     <= '0;
            r_beat_cnt <= '0;
            r_rd_owner <= '0;
            r_rd_err   <= 1'b0;
        end else begin
            if (w_ar_take) begin
                r_ar_q     <= w_ar_sel;
                r_beat_cnt <= w_ar_sel.len;
                r_rd_owner <= w_ar_gnt;
            end
            if (w_r_beat) begin
                if (r_beat_cnt != 8'd0) r_beat_cnt <= r_beat_cnt - 8'd1;
                if (imd_r_s2m.rlast != (r_beat_cnt == 8'd0)) r_rd_err <= 1'b1;
                if (imd_r_s2m.rlast) r_rd_owner <= '0;
            end
        end
    end

    // Read channel routing; AR fields always come from ar_q so the crossbar decode stays put
    always_comb begin
        imd_r_m2s         = '0;
        imd_r_m2s.araddr  = r_ar_q.addr;
        imd_r_m2s.arid    = r_ar_q.id;
        imd_r_m2s.arlen   = r_ar_q.len;
        imd_r_m2s.arsize  = r_ar_q.size;
        imd_r_m2s.arburst = r_ar_q.burst;
        imd_r_m2s.arvalid = (r_rd_state == R_AR);
        imd_r_m2s.rready  = (r_rd_state == R_DATA) && w_owner_rready;

        ifu_r_s2m         = imd_r_s2m;
        ifu_r_s2m.arready = (r_rd_state == R_IDLE) && w_ar_gnt[ARB_IFU];
        ifu_r_s2m.rvalid  = (r_rd_state == R_DATA) && r_rd_owner[ARB_IFU] && imd_r_s2m.rvalid;

        lsu_r_s2m         = imd_r_s2m;
        lsu_r_s2m.arready = (r_rd_state == R_IDLE) && w_ar_gnt[ARB_LSU];
        lsu_r_s2m.rvalid  = (r_rd_state == R_DATA) && r_rd_owner[ARB_LSU] && imd_r_s2m.rvalid;
    end

    // Write FSM state register and AW latch
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_state <= W_IDLE;
            r_aw_q     <= '0;
        end else begin
            r_wr_state <= w_wr_next;
            if ((r_wr_state == W_IDLE) && lsu_w_m2s.awvalid) r_aw_q <= aw_of(lsu_w_m2s);
        end
    end

    // Write FSM next state: AW, data beats, then response
    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            W_IDLE:  if (lsu_w_m2s.awvalid) w_wr_next = W_ADDR;
            W_ADDR:  if (imd_w_s2m.awready) w_wr_next = W_DATA;
            W_DATA:  if (lsu_w_m2s.wvalid && imd_w_s2m.wready && lsu_w_m2s.wlast) w_wr_next = W_RESP;
            W_RESP:  if (imd_w_s2m.bvalid && lsu_w_m2s.bready) w_wr_next = W_IDLE;
            default: w_wr_next = W_IDLE;
        endcase
    end

    // Write channel routing, gated by phase so early W data waits for the address
    always_comb begin
        imd_w_m2s         = lsu_w_m2s;
        imd_w_m2s.awaddr  = r_aw_q.addr;
        imd_w_m2s.awid    = r_aw_q.id;
        imd_w_m2s.awlen   = r_aw_q.len;
        imd_w_m2s.awsize  = r_aw_q.size;
        imd_w_m2s.awburst = r_aw_q.burst;
        imd_w_m2s.awvalid = (r_wr_state == W_ADDR);
        imd_w_m2s.wvalid  = (r_wr_state == W_DATA) && lsu_w_m2s.wvalid;
        imd_w_m2s.bready  = (r_wr_state == W_RESP) && lsu_w_m2s.bready;

        lsu_w_s2m         = imd_w_s2m;
        lsu_w_s2m.awready = (r_wr_state == W_IDLE);
        lsu_w_s2m.wready  = (r_wr_state == W_DATA) && imd_w_s2m.wready;
        lsu_w_s2m.bvalid  = (r_wr_state == W_RESP) && imd_w_s2m.bvalid;
    end

endmodule

// File: tb/tb_npc_axi_arbiter.sv
// tb/tb_npc_axi_arbiter.sv - directed self-checking bench for npc_axi_arbiter
module tb_npc_axi_arbiter;
    import ysyx_24080006_pkg::*;

    logic       clock;
    logic       reset;
    axi_r_m2s_t ifu_r_m2s, lsu_r_m2s, imd_r_m2s;
    axi_r_s2m_t ifu_r_s2m, lsu_r_s2m, imd_r_s2m;
    axi_w_m2s_t lsu_w_m2s, imd_w_m2s;
    axi_w_s2m_t lsu_w_s2m, imd_w_s2m;
    logic [1:0] rd_grant;
    logic       rd_err;

    int n_cmp = 0;
    int n_bad = 0;

    npc_axi_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .ifu_r_m2s (ifu_r_m2s),
        .ifu_r_s2m (ifu_r_s2m),
        .lsu_r_m2s (lsu_r_m2s),
        .lsu_r_s2m (lsu_r_s2m),
        .lsu_w_m2s (lsu_w_m2s),
        .lsu_w_s2m (lsu_w_s2m),
        .imd_r_m2s (imd_r_m2s),
        .imd_r_s2m (imd_r_s2m),
        .imd_w_m2s (imd_w_m2s),
        .imd_w_s2m (imd_w_s2m),
        .rd_grant  (rd_grant),
        .rd_err    (rd_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        ifu_r_m2s = '0;
        lsu_r_m2s = '0;
        lsu_w_m2s = '0;
        imd_r_s2m = '0;
        imd_w_s2m = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic beat(input logic [31:0] data, input logic last);
        imd_r_s2m.rvalid = 1'b1;
        imd_r_s2m.rdata  = data;
        imd_r_s2m.rlast  = last;
        settle();
    endtask

    // IFU request granted in idle, then AR issued and accepted; leaves the FSM in R_DATA
    task automatic ifu_read_to_data(input logic [31:0] addr, input logic [7:0] len, input string tag);
        ifu_r_m2s.arvalid = 1'b1;
        ifu_r_m2s.araddr  = addr;
        ifu_r_m2s.arlen   = len;
        settle();
        check_eq({tag, "_arready"}, ifu_r_s2m.arready, 1);
        tick();
        ifu_r_m2s.arvalid = 1'b0;
        settle();
        check_eq({tag, "_imd_araddr"}, imd_r_m2s.araddr, addr);
        check_eq({tag, "_grant"}, rd_grant, 2'b01);
        imd_r_s2m.arready = 1'b1;
        tick();
        imd_r_s2m.arready = 1'b0;
    endtask

    initial begin
        do_reset();
        settle();
        check_eq("rst_grant", rd_grant, 0);
        check_eq("rst_err", rd_err, 0);
        check_eq("rst_imd_arvalid", imd_r_m2s.arvalid, 0);
        check_eq("rst_imd_rready", imd_r_m2s.rready, 0);
        check_eq("rst_imd_araddr", imd_r_m2s.araddr, 0);
        check_eq("rst_imd_awvalid", imd_w_m2s.awvalid, 0);
        check_eq("rst_imd_awaddr", imd_w_m2s.awaddr, 0);
        check_eq("rst_lsu_awready", lsu_w_s2m.awready, 1);
        check_eq("rst_lsu_wready", lsu_w_s2m.wready, 0);
        check_eq("rst_ifu_arready", ifu_r_s2m.arready, 0);

        // IFU 4-beat burst at 0x8000_0000
        ifu_r_m2s.arvalid = 1'b1;
        ifu_r_m2s.araddr  = 32'h8000_0000;
        ifu_r_m2s.arlen   = 8'd3;
        settle();
        check_eq("t1_ifu_arready", ifu_r_s2m.arready, 1);
        check_eq("t1_lsu_arready", lsu_r_s2m.arready, 0);
        check_eq("t1_imd_arvalid_n", imd_r_m2s.arvalid, 0);
        tick();
        ifu_r_m2s.arvalid = 1'b0;
        settle();
        check_eq("t1_imd_arvalid_n1", imd_r_m2s.arvalid, 1);
        check_eq("t1_imd_araddr_ar", imd_r_m2s.araddr, 32'h8000_0000);
        check_eq("t1_imd_arlen", imd_r_m2s.arlen, 3);
        check_eq("t1_grant_ar", rd_grant, 2'b01);
        imd_r_s2m.arready = 1'b1;
        tick();
        imd_r_s2m.arready = 1'b0;
        ifu_r_m2s.rready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            beat(32'hD000_0000 + i, i == 3);
            check_eq("t1_imd_arvalid_data", imd_r_m2s.arvalid, 0);
            check_eq("t1_ifu_rvalid", ifu_r_s2m.rvalid, 1);
            check_eq("t1_ifu_rdata", ifu_r_s2m.rdata, 32'hD000_0000 + i);
            check_eq("t1_lsu_rvalid", lsu_r_s2m.rvalid, 0);
            check_eq("t1_imd_rready", imd_r_m2s.rready, 1);
            check_eq("t1_imd_araddr_hold", imd_r_m2s.araddr, 32'h8000_0000);
            check_eq("t1_grant_data", rd_grant, 2'b01);
            tick();
        end
        imd_r_s2m.rvalid = 1'b0;
        settle();
        check_eq("t1_grant_done", rd_grant, 0);
        check_eq("t1_rready_done", imd_r_m2s.rready, 0);
        check_eq("t1_err", rd_err, 0);

        // Simultaneous requests after reset: IFU, then LSU, then IFU again
        do_reset();
        ifu_r_m2s.arvalid = 1'b1;
        ifu_r_m2s.araddr  = 32'h8000_0200;
        lsu_r_m2s.arvalid = 1'b1;
        lsu_r_m2s.araddr  = 32'h2000_0040;
        settle();
        check_eq("t2_ifu_first", ifu_r_s2m.arready, 1);
        check_eq("t2_lsu_wait", lsu_r_s2m.arready, 0);
        tick();
        ifu_r_m2s.arvalid = 1'b0;
        settle();
        check_eq("t2_grant_ifu", rd_grant, 2'b01);
        check_eq("t2_araddr_ifu", imd_r_m2s.araddr, 32'h8000_0200);
        check_eq("t2_lsu_busy", lsu_r_s2m.arready, 0);
        imd_r_s2m.arready = 1'b1;
        tick();
        imd_r_s2m.arready = 1'b0;
        ifu_r_m2s.rready  = 1'b1;
        beat(32'h11, 1'b1);
        check_eq("t2_ifu_rvalid", ifu_r_s2m.rvalid, 1);
        check_eq("t2_lsu_rvalid_n", lsu_r_s2m.rvalid, 0);
        tick();
        imd_r_s2m.rvalid  = 1'b0;
        ifu_r_m2s.arvalid = 1'b1;
        settle();
        check_eq("t2_bubble_grant", rd_grant, 0);
        check_eq("t2_lsu_wins", lsu_r_s2m.arready, 1);
        check_eq("t2_ifu_loses", ifu_r_s2m.arready, 0);
        tick();
        lsu_r_m2s.arvalid = 1'b0;
        settle();
        check_eq("t2_grant_lsu", rd_grant, 2'b10);
        check_eq("t2_araddr_lsu", imd_r_m2s.araddr, 32'h2000_0040);
        imd_r_s2m.arready = 1'b1;
        tick();
        imd_r_s2m.arready = 1'b0;
        lsu_r_m2s.rready  = 1'b1;
        beat(32'h22, 1'b1);
        check_eq("t2_lsu_rvalid", lsu_r_s2m.rvalid, 1);
        check_eq("t2_lsu_rdata", lsu_r_s2m.rdata, 32'h22);
        check_eq("t2_ifu_rvalid_n", ifu_r_s2m.rvalid, 0);
        tick();
        imd_r_s2m.rvalid = 1'b0;
        settle();
        check_eq("t2_ifu_next", ifu_r_s2m.arready, 1);

        // LSU write, wvalid early, overlapping an IFU 2-beat read
        do_reset();
        ifu_r_m2s.rready = 1'b1;
        ifu_read_to_data(32'h8000_0100, 8'd1, "t3");
        lsu_w_m2s.awvalid = 1'b1;
        lsu_w_m2s.awaddr  = 32'h1000_0000;
        lsu_w_m2s.awlen   = 8'd0;
        lsu_w_m2s.wvalid  = 1'b1;
        lsu_w_m2s.wdata   = 32'hCAFE_F00D;
        lsu_w_m2s.wstrb   = 4'hF;
        lsu_w_m2s.wlast   = 1'b1;
        lsu_w_m2s.bready  = 1'b1;
        imd_w_s2m.wready  = 1'b1;
        beat(32'hA0, 1'b0);
        check_eq("t3_awready", lsu_w_s2m.awready, 1);
        check_eq("t3_wready_idle", lsu_w_s2m.wready, 0);
        check_eq("t3_imd_wvalid_idle", imd_w_m2s.wvalid, 0);
        check_eq("t3_ifu_rvalid0", ifu_r_s2m.rvalid, 1);
        tick();
        lsu_w_m2s.awvalid = 1'b0;
        imd_w_s2m.bvalid  = 1'b1;
        imd_w_s2m.awready = 1'b1;
        beat(32'hA1, 1'b1);
        check_eq("t3_imd_awvalid", imd_w_m2s.awvalid, 1);
        check_eq("t3_imd_awaddr", imd_w_m2s.awaddr, 32'h1000_0000);
        check_eq("t3_wready_addr", lsu_w_s2m.wready, 0);
        check_eq("t3_imd_wvalid_addr", imd_w_m2s.wvalid, 0);
        check_eq("t3_bvalid_addr", lsu_w_s2m.bvalid, 0);
        check_eq("t3_ifu_rdata1", ifu_r_s2m.rdata, 32'hA1);
        tick();
        imd_w_s2m.awready = 1'b0;
        imd_r_s2m.rvalid  = 1'b0;
        settle();
        check_eq("t3_rd_done", rd_grant, 0);
        check_eq("t3_rd_err", rd_err, 0);
        check_eq("t3_awvalid_off", imd_w_m2s.awvalid, 0);
        check_eq("t3_wready_data", lsu_w_s2m.wready, 1);
        check_eq("t3_imd_wvalid", imd_w_m2s.wvalid, 1);
        check_eq("t3_imd_wdata", imd_w_m2s.wdata, 32'hCAFE_F00D);
        check_eq("t3_bready_data", imd_w_m2s.bready, 0);
        check_eq("t3_bvalid_data", lsu_w_s2m.bvalid, 0);
        tick();
        lsu_w_m2s.wvalid = 1'b0;
        settle();
        check_eq("t3_wready_resp", lsu_w_s2m.wready, 0);
        check_eq("t3_bvalid_resp", lsu_w_s2m.bvalid, 1);
        check_eq("t3_bready_resp", imd_w_m2s.bready, 1);
        check_eq("t3_awaddr_resp", imd_w_m2s.awaddr, 32'h1000_0000);
        tick();
        imd_w_s2m.bvalid = 1'b0;
        settle();
        check_eq("t3_awready_back", lsu_w_s2m.awready, 1);
        check_eq("t3_bready_idle", imd_w_m2s.bready, 0);
        check_eq("t3_awaddr_kept", imd_w_m2s.awaddr, 32'h1000_0000);

        // Early rlast on beat 2 of a 4-beat burst
        ifu_read_to_data(32'h8000_0300, 8'd3, "t4");
        beat(32'hB0, 1'b0);
        tick();
        beat(32'hB1, 1'b1);
        check_eq("t4_err_before", rd_err, 0);
        tick();
        imd_r_s2m.rvalid = 1'b0;
        settle();
        check_eq("t4_grant_idle", rd_grant, 0);
        check_eq("t4_err_set", rd_err, 1);
        check_eq("t4_rready_idle", imd_r_m2s.rready, 0);
        tick();
        tick();
        tick();
        check_eq("t4_err_sticky", rd_err, 1);

        // Reset during the first data beat, then a clean read
        ifu_read_to_data(32'h8000_0380, 8'd1, "t5");
        beat(32'hC0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        imd_r_s2m.rvalid = 1'b0;
        settle();
        check_eq("t5_grant_rst", rd_grant, 0);
        check_eq("t5_arvalid_rst", imd_r_m2s.arvalid, 0);
        check_eq("t5_rready_rst", imd_r_m2s.rready, 0);
        check_eq("t5_err_rst", rd_err, 0);
        check_eq("t5_araddr_rst", imd_r_m2s.araddr, 0);
        ifu_read_to_data(32'h8000_0400, 8'd0, "t5b");
        beat(32'hC1, 1'b1);
        check_eq("t5_rdata", ifu_r_s2m.rdata, 32'hC1);
        check_eq("t5_rvalid", ifu_r_s2m.rvalid, 1);
        tick();
        imd_r_s2m.rvalid = 1'b0;
        settle();
        check_eq("t5_grant_done", rd_grant, 0);
        check_eq("t5_err_clean", rd_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/npc_axi_arbiter.md
# npc_axi_arbiter

Two-requester AXI arbiter placed in front of the NPC address crossbar. It shares the single upstream AXI port (`imd_*`) between the instruction fetch unit (read only) and the load/store unit (read and write). Each address phase is registered. The granted address is then held stable on the downstream port until the transaction fully completes, because the crossbar routes every response beat by decoding the live `araddr`/`awaddr`.

## Interface
Parameters: none. Types are `axi_r_m2s_t`, `axi_r_s2m_t`, `axi_w_m2s_t` and `axi_w_s2m_t`, all from `ysyx_24080006_pkg`.
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `ifu_r_m2s`  in  axi_r_m2s_t  IFU read request
- `ifu_r_s2m`  out  axi_r_s2m_t  IFU read response
- `lsu_r_m2s`  in  axi_r_m2s_t  LSU read request
- `lsu_r_s2m`  out  axi_r_s2m_t  LSU read response
- `lsu_w_m2s`  in  axi_w_m2s_t  LSU write request
- `lsu_w_s2m`  out  axi_w_s2m_t  LSU write response
- `imd_r_m2s`  out  axi_r_m2s_t  read port toward the crossbar
- `imd_r_s2m`  in  axi_r_s2m_t
- `imd_w_m2s`  out  axi_w_m2s_t  write port toward the crossbar
- `imd_w_s2m`  in  axi_w_s2m_t
- `rd_grant`  out  2  one-hot read owner: [0] is IFU, [1] is LSU; 0 when idle
- `rd_err`  out  1  sticky flag for a burst-length violation

## Operation
Read FSM: `R_IDLE` → `R_AR` → `R_DATA`.
- `R_IDLE`:
  - If any requester has `arvalid`, pick a winner and assert `arready` to the winner only, combinationally, in the same cycle.
  - Latch the winner's `araddr/arid/arlen/arsize/arburst` into `ar_q` and load the beat counter with `arlen`. Go to `R_AR`.
  - Round robin: when both request, the requester not granted last wins. After reset, the IFU wins.
- `R_AR`: drive `imd arvalid=1` with `ar_q`. On `arready`, go to `R_DATA`.
- `R_DATA`:
  - Connect `rvalid/rdata/rlast` to the owner and `rready` from the owner. The non-owner sees `rvalid=0`.
  - Each beat handshake decrements the counter.
  - On the handshake with `rlast`, go to `R_IDLE` and clear `rd_grant`.
  - Set `rd_err` if `rlast` arrives with counter≠0, or a beat arrives with counter==0 and no `rlast`. Termination always follows `rlast`.
- `imd_r_m2s.araddr` (and the other AR fields) equal `ar_q` in every state. `arvalid` is asserted only in `R_AR`. `rready` is 0 outside `R_DATA`.

Write FSM: `W_IDLE` → `W_ADDR` → `W_DATA` → `W_RESP`. The LSU is the only writer.
- `W_IDLE`: assert `lsu awready=1`. On `awvalid`, latch the AW fields into `aw_q` and go to `W_ADDR`.
- `W_ADDR`: drive `imd awvalid=1` with `aw_q`. On `awready`, go to `W_DATA`.
- `W_DATA`: pass `wvalid/wdata/wstrb/wlast` down and `wready` up. On the handshake with `wlast`, go to `W_RESP`.
- `W_RESP`: pass `bvalid` up and `bready` down. On the handshake, go to `W_IDLE`.
- `imd_w_m2s.awaddr` equals `aw_q` in every state. `lsu wready=0` outside `W_DATA`. `lsu bvalid=0` outside `W_RESP`.

The read and write FSMs are independent and may be active concurrently.

## Timing
- Reset values:
  - both FSMs idle; `ar_q` and `aw_q` = 0; counter = 0; round-robin pointer favours the IFU
  - all downstream valid/ready = 0; upstream `arready`/`awready` follow idle-state rules
  - `rd_grant=0`, `rd_err=0`
- AR latency: requester `arvalid` and `arready` at cycle N, then `imd arvalid` at N+1. AW latency is the same.
- R, W and B channels pass through combinationally, with 0 cycles of latency.
- The arbiter returns to `R_IDLE` the cycle after the last beat, so back-to-back reads have a 1-cycle bubble. The next grant can be issued in that `R_IDLE` cycle.
- A request arriving while the arbiter is busy sees `arready=0`. The requester holds `arvalid` and is served after the current burst.
- Simultaneous read requests in `R_IDLE`: exactly one winner. The loser is served in the next grant cycle.
- Reset asserted mid-burst: the next edge forces idle and zeroes all downstream valid/ready. Abandoned downstream transactions are cleared by the system reset.

## Structure
- `ysyx_24080006_pkg`: add `rd_arb_state_e` and `wr_arb_state_e` enums and the requester index constants `ARB_IFU=0` and `ARB_LSU=1`.
- One sub-module: `npc_rr_arb2`, a two-way round-robin picker with inputs `req[1:0]`, `update` and `clock/reset`, and output one-hot `gnt[1:0]`.

## Test plan
- IFU read of `0x8000_0000` with `arlen=3`: `imd arvalid` one cycle after IFU `arready`; 4 beats routed to the IFU; `imd araddr` stays `0x8000_0000` until `rlast`; `rd_grant` goes 01 → 00.
- IFU and LSU `arvalid` in the same cycle right after reset: the IFU is granted first and the LSU second. When both request again, the LSU wins.
- LSU write to `0x1000_0000` with `awlen=0` while an IFU read burst is in flight: both complete independently; `imd awaddr` holds `0x1000_0000` through `W_RESP`.
- Slave returns `rlast` on beat 2 of an `arlen=3` burst: the FSM returns to idle and `rd_err=1` stays set until reset.
- `reset` asserted during `R_DATA` beat 1: the next cycle has `rd_grant=0`, `imd arvalid=0` and `imd rready=0`; a new IFU read then completes normally.
- LSU `wvalid` asserted before `awvalid`: `wready` stays 0 until `W_DATA`; the data is accepted only afterwards.
